// File: rtl/mem_refill_arbiter.sv
// mem_refill_arbiter: shares one memory port between ICache refills and
// DCache refills/writebacks. Round-robin grant, LINE_WORDS-beat burst,
// one beat per mem_ack, then a one-cycle release with the done pulse.
module mem_refill_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int LINE_WORDS = 4
) (
   input  logic              clk,
   input  logic              CpuRst,
   input  logic              ic_req,
   input  logic [ADDR_W-1:0] ic_addr,
   output logic [DATA_W-1:0] ic_rdata,
   output logic              ic_rvalid,
   output logic              ic_done,
   input  logic              dc_req,
   input  logic              dc_we,
   input  logic [ADDR_W-1:0] dc_addr,
   input  logic [DATA_W-1:0] dc_wdata,
   output logic              dc_wnext,
   output logic [DATA_W-1:0] dc_rdata,
   output logic              dc_rvalid,
   output logic              dc_done,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata
);
   localparam int BW    = $clog2(LINE_WORDS);
   localparam int OFF_W = BW + 2;
   localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((LINE_WORDS * 4) - 1);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_BURST = 2'd1, S_RELEASE = 2'd2} state_t;

   state_t            state, state_nx;
   logic [BW-1:0]     beat, beat_nx, beat_inc;
   logic              owner_d, owner_d_nx;   // 1 = DCache owns the port
   logic              last_d, last_d_nx;     // last grant went to DCache
   logic              we_r, we_nx;
   logic [ADDR_W-1:0] base, base_nx, sel_addr;
   logic              mem_req_nx, mem_we_nx;
   logic [ADDR_W-1:0] mem_addr_nx;
   logic [DATA_W-1:0] ic_rdata_nx, dc_rdata_nx;
   logic              ic_rvalid_nx, ic_done_nx, dc_rvalid_nx, dc_wnext_nx, dc_done_nx;
   logic              grant_d, beat_ack, last_beat;

   // Tie goes to whoever was not granted last.
   assign grant_d   = dc_req & (~ic_req | ~last_d);
   assign sel_addr  = grant_d ? dc_addr : ic_addr;
   assign beat_ack  = (state == S_BURST) & mem_req & mem_ack;
   assign last_beat = (beat == BW'(LINE_WORDS - 1));
   assign beat_inc  = beat + BW'(1);

   // Write data passes straight through while a DCache writeback owns the port.
   assign mem_wdata = ((state == S_BURST) && owner_d && we_r) ? dc_wdata : '0;

   // State and all registered outputs; reset aborts any burst without a done.
   always_ff @(posedge clk or posedge CpuRst) begin
      if (CpuRst) begin
         state     <= S_IDLE;
         beat      <= '0;
         owner_d   <= 1'b0;
         last_d    <= 1'b0;
         we_r      <= 1'b0;
         base      <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         ic_rdata  <= '0;
         ic_rvalid <= 1'b0;
         ic_done   <= 1'b0;
         dc_rdata  <= '0;
         dc_rvalid <= 1'b0;
         dc_wnext  <= 1'b0;
         dc_done   <= 1'b0;
      end else begin
         state     <= state_nx;
         beat      <= beat_nx;
         owner_d   <= owner_d_nx;
         last_d    <= last_d_nx;
         we_r      <= we_nx;
         base      <= base_nx;
         mem_req   <= mem_req_nx;
         mem_we    <= mem_we_nx;
         mem_addr  <= mem_addr_nx;
         ic_rdata  <= ic_rdata_nx;
         ic_rvalid <= ic_rvalid_nx;
         ic_done   <= ic_done_nx;
         dc_rdata  <= dc_rdata_nx;
         dc_rvalid <= dc_rvalid_nx;
         dc_wnext  <= dc_wnext_nx;
         dc_done   <= dc_done_nx;
      end
   end

   // Next state: grant from idle, leave burst on the last acked beat.
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:    if (ic_req | dc_req) state_nx = S_BURST;
         S_BURST:   if (beat_ack & last_beat) state_nx = S_RELEASE;
         S_RELEASE: state_nx = S_IDLE;
         default:   state_nx = S_IDLE;
      endcase
   end

   // Next values of the registered outputs and burst context.
   always_comb begin
      beat_nx      = beat;
      owner_d_nx   = owner_d;
      last_d_nx    = last_d;
      we_nx        = we_r;
      base_nx      = base;
      mem_req_nx   = mem_req;
      mem_we_nx    = mem_we;
      mem_addr_nx  = mem_addr;
      ic_rdata_nx  = ic_rdata;
      dc_rdata_nx  = dc_rdata;
      ic_rvalid_nx = 1'b0;
      ic_done_nx   = 1'b0;
      dc_rvalid_nx = 1'b0;
      dc_wnext_nx  = 1'b0;
      dc_done_nx   = 1'b0;
      if ((state == S_IDLE) && (ic_req | dc_req)) begin
         owner_d_nx  = grant_d;
         last_d_nx   = grant_d;
         base_nx     = sel_addr & LINE_MASK;
         we_nx       = grant_d & dc_we;
         beat_nx     = '0;
         mem_req_nx  = 1'b1;
         mem_addr_nx = sel_addr & LINE_MASK;
         mem_we_nx   = grant_d & dc_we;
      end else if (beat_ack) begin
         if (we_r) begin
            dc_wnext_nx = 1'b1;
         end else if (owner_d) begin
            dc_rdata_nx  = mem_rdata;
            dc_rvalid_nx = 1'b1;
         end else begin
            ic_rdata_nx  = mem_rdata;
            ic_rvalid_nx = 1'b1;
         end
         if (last_beat) begin
            mem_req_nx = 1'b0;
            mem_we_nx  = 1'b0;
            dc_done_nx = owner_d;
            ic_done_nx = ~owner_d;
         end else begin
            // Beat index only fills the in-line offset, so no carry into the tag.
            beat_nx     = beat_inc;
            mem_addr_nx = base | {{(ADDR_W - OFF_W){1'b0}}, beat_inc, 2'b00};
         end
      end
   end

endmodule

// File: tb/tb_mem_refill_arbiter.sv
// tb_mem_refill_arbiter: table-driven bursts, directed corner sequences and
// random traffic, all compared against a transaction-level reference model.
module tb_mem_refill_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int LW = 4;

   logic          clk = 1'b0;
   logic          CpuRst = 1'b1;
   logic          ic_req = 1'b0, dc_req = 1'b0, dc_we = 1'b0, mem_ack = 1'b0;
   logic [AW-1:0] ic_addr = '0, dc_addr = '0;
   logic [DW-1:0] dc_wdata = '0, mem_rdata = '0;
   logic [DW-1:0] ic_rdata, dc_rdata, mem_wdata;
   logic          ic_rvalid, ic_done, dc_wnext, dc_rvalid, dc_done, mem_req, mem_we;
   logic [AW-1:0] mem_addr;

   always #5 clk = ~clk;

   mem_refill_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LINE_WORDS(LW)) dut (
      .clk(clk), .CpuRst(CpuRst),
      .ic_req(ic_req), .ic_addr(ic_addr), .ic_rdata(ic_rdata), .ic_rvalid(ic_rvalid), .ic_done(ic_done),
      .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata), .dc_wnext(dc_wnext),
      .dc_rdata(dc_rdata), .dc_rvalid(dc_rvalid), .dc_done(dc_done),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   int n_chk = 0, n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model (one transaction at a time) ----------------
   int            m_own = 0;       // 1 = ICache, 2 = DCache
   bit            m_busy = 0, m_rel = 0, m_last_d = 0, m_we = 0;
   int            m_beat = 0;
   logic [AW-1:0] m_base = '0;
   bit            e_ic_rv = 0, e_dc_rv = 0, e_wn = 0, e_ic_done = 0, e_dc_done = 0;
   logic [DW-1:0] e_ic_rd = '0, e_dc_rd = '0;

   task automatic model_tick();
      if (CpuRst) begin
         m_own = 0; m_busy = 0; m_rel = 0; m_last_d = 0; m_we = 0; m_beat = 0; m_base = '0;
         e_ic_rv = 0; e_dc_rv = 0; e_wn = 0; e_ic_done = 0; e_dc_done = 0;
         e_ic_rd = '0; e_dc_rd = '0;
      end else begin
         e_ic_rv = 0; e_dc_rv = 0; e_wn = 0; e_ic_done = 0; e_dc_done = 0;
         if (m_rel) begin
            m_rel = 0;
         end else if (m_busy) begin
            if (mem_ack) begin
               if (m_we) e_wn = 1;
               else if (m_own == 2) begin e_dc_rv = 1; e_dc_rd = mem_rdata; end
               else begin e_ic_rv = 1; e_ic_rd = mem_rdata; end
               if (m_beat == LW - 1) begin
                  m_busy = 0; m_rel = 1;
                  if (m_own == 2) e_dc_done = 1; else e_ic_done = 1;
               end else begin
                  m_beat++;
               end
            end
         end else if (ic_req || dc_req) begin
            m_own    = (dc_req && !(ic_req && m_last_d)) ? 2 : 1;
            m_last_d = (m_own == 2);
            m_base   = (((m_own == 2) ? dc_addr : ic_addr) / (LW * 4)) * (LW * 4);
            m_we     = (m_own == 2) && dc_we;
            m_beat   = 0;
            m_busy   = 1;
         end
      end
   endtask

   always @(posedge clk or posedge CpuRst) model_tick();

   // ---------------- cycle-by-cycle comparison against the model ----------------
   always @(negedge clk) begin
      if (!CpuRst) begin
         chk("mem_req", 32'(mem_req), 32'(m_busy));
         chk("mem_we", 32'(mem_we), 32'(m_busy && m_we));
         if (m_busy) chk("mem_addr", mem_addr, m_base + 32'(4 * m_beat));
         chk("mem_wdata", mem_wdata, (m_busy && m_own == 2 && m_we) ? dc_wdata : 32'd0);
         chk("ic_rvalid", 32'(ic_rvalid), 32'(e_ic_rv));
         chk("dc_rvalid", 32'(dc_rvalid), 32'(e_dc_rv));
         chk("dc_wnext", 32'(dc_wnext), 32'(e_wn));
         chk("ic_done", 32'(ic_done), 32'(e_ic_done));
         chk("dc_done", 32'(dc_done), 32'(e_dc_done));
         chk("ic_rdata", ic_rdata, e_ic_rd);
         chk("dc_rdata", dc_rdata, e_dc_rd);
      end
   end

   // ---------------- observation log for the directed sequences ----------------
   int            cyc = 0, n_ic_rv = 0, n_dc_rv = 0, n_wn = 0, n_ic_dn = 0, n_dc_dn = 0;
   int            first_dn = 0, ic_dn_cyc = 0, dc_dn_cyc = 0, rep_cyc = 0;
   int            rise_q[$];
   logic [AW-1:0] alog[$];
   logic          prev_req = 1'b0;

   always @(negedge clk) begin
      cyc++;
      if (ic_rvalid) n_ic_rv++;
      if (dc_rvalid) n_dc_rv++;
      if (dc_wnext) n_wn++;
      if (ic_rvalid || dc_rvalid || dc_wnext) rep_cyc = cyc;
      if (ic_done) begin n_ic_dn++; ic_dn_cyc = cyc; if (first_dn == 0) first_dn = 1; end
      if (dc_done) begin n_dc_dn++; dc_dn_cyc = cyc; if (first_dn == 0) first_dn = 2; end
      if (mem_req && !prev_req) rise_q.push_back(cyc);
      if (mem_req && mem_ack) alog.push_back(mem_addr);
      prev_req = mem_req;
   end

   task automatic clr_mon();
      n_ic_rv = 0; n_dc_rv = 0; n_wn = 0; n_ic_dn = 0; n_dc_dn = 0; first_dn = 0;
      rise_q.delete(); alog.delete();
   endtask

   // ---------------- cache / memory behaviour ----------------
   int ack_mode = 0;   // 0 fixed gap, 1 random, 2 manual
   int gap = 0, wcnt = 0;
   bit rnd_req = 0;

   task automatic step();
      @(posedge clk);
      #2;
      mem_rdata = $urandom;
      dc_wdata  = $urandom;
      if (e_ic_done) ic_req = 1'b0;
      if (e_dc_done) dc_req = 1'b0;
      case (ack_mode)
         0: if (m_busy) begin
               if (wcnt >= gap) begin mem_ack = 1'b1; wcnt = 0; end
               else begin mem_ack = 1'b0; wcnt++; end
            end else begin
               mem_ack = 1'b0; wcnt = 0;
            end
         1: mem_ack = ($urandom_range(0, 2) == 0);
         default: ;
      endcase
      if (rnd_req) begin
         if (!ic_req && $urandom_range(0, 3) == 0) begin ic_req = 1'b1; ic_addr = $urandom; end
         if (!dc_req && $urandom_range(0, 3) == 0) begin
            dc_req = 1'b1; dc_we = 1'($urandom_range(0, 1)); dc_addr = $urandom;
         end
      end
   endtask

   task automatic wait_done(input int who, input string nm);
      int k = 0;
      while (((who == 2) ? !e_dc_done : !e_ic_done) && k < 400) begin step(); k++; end
      chk({nm, "_timeout"}, 32'(k >= 400), 32'd0);
      step();
   endtask

   typedef struct {
      bit            is_d;
      bit            we;
      logic [AW-1:0] addr;
      int            gap;
      logic [AW-1:0] a0;
      logic [AW-1:0] a3;
      int            ic_rv;
      int            dc_rv;
      int            wn;
   } vec_t;

   vec_t tv[4];

   initial begin
      int k;
      tv[0] = '{1'b0, 1'b0, 32'h0000_1234, 0, 32'h0000_1230, 32'h0000_123C, 4, 0, 0};
      tv[1] = '{1'b1, 1'b1, 32'h0000_2000, 3, 32'h0000_2000, 32'h0000_200C, 0, 0, 4};
      tv[2] = '{1'b1, 1'b0, 32'h0000_3FFF, 1, 32'h0000_3FF0, 32'h0000_3FFC, 0, 4, 0};
      tv[3] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 2, 32'hFFFF_FFF0, 32'hFFFF_FFFC, 4, 0, 0};

      // reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_ic_done", 32'(ic_done), 32'd0);
      chk("rst_dc_done", 32'(dc_done), 32'd0);
      chk("rst_ic_rdata", ic_rdata, 32'd0);
      @(posedge clk);
      #2 CpuRst = 1'b0;

      // single bursts from the table
      for (int i = 0; i < 4; i++) begin
         clr_mon();
         ack_mode = 0; gap = tv[i].gap;
         if (tv[i].is_d) begin dc_req = 1'b1; dc_we = tv[i].we; dc_addr = tv[i].addr; end
         else begin ic_req = 1'b1; ic_addr = tv[i].addr; end
         wait_done(tv[i].is_d ? 2 : 1, "tv");
         chk("tv_beats", 32'(alog.size()), 32'd4);
         if (alog.size() == 4) begin
            chk("tv_addr0", alog[0], tv[i].a0);
            chk("tv_addr1", alog[1], tv[i].a0 + 32'd4);
            chk("tv_addr3", alog[3], tv[i].a3);
         end
         chk("tv_ic_rv", 32'(n_ic_rv), 32'(tv[i].ic_rv));
         chk("tv_dc_rv", 32'(n_dc_rv), 32'(tv[i].dc_rv));
         chk("tv_wnext", 32'(n_wn), 32'(tv[i].wn));
         chk("tv_ndone", 32'(n_ic_dn + n_dc_dn), 32'd1);
         chk("tv_done_with_last", 32'(tv[i].is_d ? dc_dn_cyc : ic_dn_cyc), 32'(rep_cyc));
      end

      // tie after reset: D first, I two cycles after dc_done; then D alone, tie -> I
      CpuRst = 1'b1;
      step(); step();
      CpuRst = 1'b0;
      clr_mon(); gap = 0;
      ic_req = 1'b1; ic_addr = 32'h100; dc_req = 1'b1; dc_we = 1'b0; dc_addr = 32'h200;
      wait_done(2, "t2_d");
      wait_done(1, "t2_i");
      chk("t2_first", 32'(first_dn), 32'd2);
      chk("t2_rises", 32'(rise_q.size()), 32'd2);
      if (rise_q.size() == 2) chk("t2_i_req_lat", 32'(rise_q[1] - dc_dn_cyc), 32'd2);
      dc_req = 1'b1; dc_addr = 32'h300;
      wait_done(2, "t2_d2");
      clr_mon();
      ic_req = 1'b1; ic_addr = 32'h400; dc_req = 1'b1; dc_addr = 32'h500;
      wait_done(1, "t2_i2");
      wait_done(2, "t2_d3");
      chk("t2_repeat_first", 32'(first_dn), 32'd1);

      // ack withheld for 10 cycles on beat 1
      clr_mon();
      ack_mode = 2; mem_ack = 1'b0; ic_req = 1'b1; ic_addr = 32'h4008;
      step();
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
      for (int j = 0; j < 10; j++) begin
         @(negedge clk);
         chk("t4_req", 32'(mem_req), 32'd1);
         chk("t4_addr", mem_addr, 32'h4004);
         if (j > 0) chk("t4_rvalid", 32'(ic_rvalid), 32'd0);
         step();
      end
      ack_mode = 0; gap = 0;
      wait_done(1, "t4");
      chk("t4_nrv", 32'(n_ic_rv), 32'd4);

      // reset at beat 2
      clr_mon();
      ic_req = 1'b1; ic_addr = 32'h6010;
      k = 0;
      while (!(m_busy && m_beat == 2) && k < 50) begin step(); k++; end
      chk("t5_reach_timeout", 32'(k >= 50), 32'd0);
      #1 CpuRst = 1'b1; ic_req = 1'b0;
      #1;
      chk("t5_mem_req", 32'(mem_req), 32'd0);
      chk("t5_mem_addr", mem_addr, 32'd0);
      chk("t5_ic_rvalid", 32'(ic_rvalid), 32'd0);
      chk("t5_ic_rdata", ic_rdata, 32'd0);
      step(); step();
      CpuRst = 1'b0;
      step();
      chk("t5_no_done", 32'(n_ic_dn), 32'd0);
      clr_mon();
      ic_req = 1'b1; ic_addr = 32'h7024; dc_req = 1'b1; dc_we = 1'b0; dc_addr = 32'h5008;
      wait_done(2, "t5_d");
      wait_done(1, "t5_i");
      chk("t5_first", 32'(first_dn), 32'd2);
      chk("t5_beats", 32'(alog.size()), 32'd8);
      if (alog.size() == 8) begin
         chk("t5_d_base", alog[0], 32'h5000);
         chk("t5_i_base", alog[4], 32'h7020);
      end

      // I request raised mid D burst
      clr_mon(); gap = 1;
      dc_req = 1'b1; dc_we = 1'b0; dc_addr = 32'h8000;
      k = 0;
      while (!(m_busy && m_beat == 1) && k < 50) begin step(); k++; end
      chk("t6_reach_timeout", 32'(k >= 50), 32'd0);
      ic_req = 1'b1; ic_addr = 32'h9000;
      wait_done(2, "t6_d");
      chk("t6_ic_quiet", 32'(n_ic_rv + n_ic_dn), 32'd0);
      wait_done(1, "t6_i");
      chk("t6_rises", 32'(rise_q.size()), 32'd2);
      if (rise_q.size() == 2) chk("t6_i_req_lat", 32'(rise_q[1] - dc_dn_cyc), 32'd2);

      // random traffic
      rnd_req = 1; ack_mode = 1;
      repeat (3000) step();
      rnd_req = 0; ack_mode = 0; gap = 0;
      repeat (80) step();
      @(negedge clk);
      chk("drain_idle", 32'(mem_req), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
